// File: rtl/sram_req_ctrl_2048x39_if.sv
// Request, response and macro-pin bundle for the 2048x39 SRAM request front-end.
// The slave modport is the controller; the master modport is its environment.
interface sram_req_ctrl_2048x39_if #(
  parameter int BITS       = 39,
  parameter int ADDR_WIDTH = 11
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [BITS-1:0]       req_wdata_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [BITS-1:0]       resp_data_o;
  logic                  sram_ce_o;
  logic                  sram_we_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [BITS-1:0]       sram_wd_o;
  logic [BITS-1:0]       sram_rd_i;
  logic                  busy_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i, sram_rd_i,
    input  req_ready_o, resp_valid_o, resp_data_o, sram_ce_o, sram_we_o,
           sram_addr_o, sram_wd_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i, sram_rd_i,
    output req_ready_o, resp_valid_o, resp_data_o, sram_ce_o, sram_we_o,
           sram_addr_o, sram_wd_o, busy_o
  );
endinterface

// File: rtl/sram_req_ctrl_2048x39.sv
// Request front-end for the 2048x39 SRAM macro: one access per cycle, credit-limited
// so every issued read has a guaranteed slot in the FWFT response FIFO.
module sram_req_ctrl_2048x39 #(
  parameter int BITS        = 39,
  parameter int ADDR_WIDTH  = 11,
  parameter int RESP_DEPTH  = 2,
  parameter int INIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_req_ctrl_2048x39_if.slave bus
);

  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int CU_W   = CNT_W + 1;
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic {
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t            state_reg;
  logic [INIT_W-1:0] init_cnt_reg;
  logic              rd_pending_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  fifo_count_reg;
  logic [CNT_W-1:0]  fifo_count_next;
  logic [BITS-1:0]   mem_reg [RESP_DEPTH];

  logic              resp_valid;
  logic              pop;
  logic              push;
  logic              req_ready;
  logic              fire;
  logic [CU_W-1:0]   credits_used;

  assign resp_valid = (fifo_count_reg != '0);
  assign pop        = resp_valid & bus.resp_ready_i;
  assign push       = rd_pending_reg;

  // A slot freed by this cycle's pop may be reused by this cycle's request.
  assign credits_used = CU_W'(fifo_count_reg) + CU_W'(rd_pending_reg) - CU_W'(pop);
  assign req_ready    = (state_reg == ST_RUN) && (credits_used < CU_W'(RESP_DEPTH));
  assign fire         = bus.req_valid_i & req_ready;

  assign bus.req_ready_o  = req_ready;
  assign bus.sram_ce_o    = fire;
  assign bus.sram_we_o    = fire & bus.req_we_i;
  assign bus.sram_addr_o  = bus.req_addr_i;
  assign bus.sram_wd_o    = bus.req_wdata_i;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_data_o  = resp_valid ? mem_reg[rd_ptr_reg] : '0;
  assign bus.busy_o       = (state_reg == ST_WAIT) | rd_pending_reg | resp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_WAIT;
      init_cnt_reg <= INIT_W'(INIT_CYCLES - 1);
    end else if (state_reg == ST_WAIT) begin
      if (init_cnt_reg == '0) begin
        state_reg <= ST_RUN;
      end else begin
        init_cnt_reg <= init_cnt_reg - 1'b1;
      end
    end
  end

  always_comb begin
    fifo_count_next = fifo_count_reg;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
      2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  // The macro output is only meaningful the cycle after a read was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      rd_pending_reg <= fire & ~bus.req_we_i;
      fifo_count_reg <= fifo_count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= bus.sram_rd_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_count_reg == CNT_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_sram_req_ctrl_2048x39.sv
// Self-checking bench: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (expected-response queue with issue timestamps).
module tb_sram_req_ctrl_2048x39;
  localparam int BITS  = 39;
  localparam int AW    = 11;
  localparam int DEPTH = 2;
  localparam int INIT  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_req_ctrl_2048x39_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus();

  sram_req_ctrl_2048x39 #(
    .BITS(BITS), .ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int wait_left = INIT;
  logic [BITS-1:0] q_data[$];
  int              q_cyc[$];
  logic [BITS-1:0] ref_mem  [2**AW] = '{default: '0};
  logic [BITS-1:0] sram_mem [2**AW] = '{default: '0};

  function automatic logic [BITS-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[BITS-1:0];
  endfunction

  // Macro stub: output is garbage whenever the previous cycle was not a read.
  always @(posedge clk) begin
    if (bus.sram_ce_o) begin
      if (bus.sram_we_o) sram_mem[bus.sram_addr_o] <= bus.sram_wd_o;
      else bus.sram_rd_i <= sram_mem[bus.sram_addr_o];
    end else begin
      bus.sram_rd_i <= rand_word();
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(output logic fired);
    logic e_valid, e_pop, e_ready, e_fire, e_busy;
    int outstanding;
    @(negedge clk);
    outstanding = q_data.size();
    e_valid = 1'b0;
    if (!reset && outstanding > 0) e_valid = (cyc >= q_cyc[0] + 2);
    e_pop   = e_valid && bus.resp_ready_i;
    e_ready = !reset && wait_left == 0 && (outstanding - (e_pop ? 1 : 0)) < DEPTH;
    e_fire  = bus.req_valid_i && e_ready;
    e_busy  = reset || wait_left != 0 || outstanding > 0;
    chk("req_ready", 64'(bus.req_ready_o), 64'(e_ready));
    chk("resp_valid", 64'(bus.resp_valid_o), 64'(e_valid));
    chk("sram_ce", 64'(bus.sram_ce_o), 64'(e_fire));
    chk("sram_we", 64'(bus.sram_we_o), 64'(e_fire && bus.req_we_i));
    chk("busy", 64'(bus.busy_o), 64'(e_busy));
    if (e_fire) begin
      chk("sram_addr", 64'(bus.sram_addr_o), 64'(bus.req_addr_i));
      if (bus.req_we_i) chk("sram_wd", 64'(bus.sram_wd_o), 64'(bus.req_wdata_i));
    end
    if (e_valid) chk("resp_data", 64'(bus.resp_data_o), 64'(q_data[0]));
    if (reset) chk("resp_data_rst", 64'(bus.resp_data_o), 64'd0);
    if (e_pop) begin
      void'(q_data.pop_front());
      void'(q_cyc.pop_front());
    end
    if (e_fire) begin
      if (bus.req_we_i) begin
        ref_mem[bus.req_addr_i] = bus.req_wdata_i;
      end else begin
        q_data.push_back(ref_mem[bus.req_addr_i]);
        q_cyc.push_back(cyc);
      end
    end
    if (!reset && wait_left > 0) wait_left--;
    fired = e_fire;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [BITS-1:0] data);
    logic f;
    int n;
    n = 0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = data;
    do begin
      tick(f);
      n++;
    end while (!f && n < 50);
    chk("send_accepted", 64'(f), 64'd1);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd1);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    q_data.delete();
    q_cyc.delete();
    wait_left = INIT;
  endtask

  initial begin
    logic f;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.resp_ready_i = 1'b1;

    idle(2);
    reset = 1'b0;

    // Request held valid through the settle period: ready must rise on the fifth cycle.
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 11'h000;
    for (int i = 0; i < INIT; i++) begin
      tick(f);
      chk("wait_no_fire", 64'(f), 64'd0);
    end
    tick(f);
    chk("first_fire_after_wait", 64'(f), 64'd1);
    bus.req_valid_i = 1'b0;
    idle(3);

    send(1'b1, 11'h123, 39'h55_AAAA_AAAA);
    send(1'b0, 11'h123, '0);
    idle(4);

    // Backpressure: two reads fill the credits, third waits until a pop.
    bus.resp_ready_i = 1'b0;
    send(1'b1, 11'h010, 39'h11_1111_1111);
    send(1'b1, 11'h011, 39'h22_2222_2222);
    send(1'b1, 11'h012, 39'h33_3333_3333);
    send(1'b0, 11'h010, '0);
    send(1'b0, 11'h011, '0);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 11'h012;
    for (int i = 0; i < 3; i++) begin
      tick(f);
      chk("third_read_held", 64'(f), 64'd0);
    end
    bus.resp_ready_i = 1'b1;
    send(1'b0, 11'h012, '0);
    idle(4);

    // Streaming reads over a freshly written block.
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), rand_word());
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), '0);
    idle(4);

    // Reset with responses buffered: nothing stale may appear afterwards.
    bus.resp_ready_i = 1'b0;
    send(1'b0, 11'h003, '0);
    send(1'b0, 11'h004, '0);
    idle(2);
    apply_reset();
    idle(2);
    reset = 1'b0;
    bus.resp_ready_i = 1'b1;
    idle(INIT + 4);

    for (int i = 0; i < 10000; i++) begin
      bus.req_valid_i  = ($urandom_range(0, 3) != 0);
      bus.req_we_i     = $urandom_range(0, 1) == 1;
      bus.req_addr_i   = AW'($urandom_range(0, 63));
      bus.req_wdata_i  = rand_word();
      bus.resp_ready_i = ($urandom_range(0, 2) != 0);
      tick(f);
    end
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    idle(6);
    chk("drained", 64'(q_data.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
